// File: rtl/bcam_pkg.sv
// Shared definitions for the bcam lookup path: default geometry, the
// lookup FSM state encoding and the lookup-result record.
package bcam_pkg;

    localparam int BCAM_MEMLEN   = 32;
    localparam int BCAM_MEMDBITS = 9;
    localparam int BCAM_MEMDEPTH = 1 << BCAM_MEMDBITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lookup_state_t;

    typedef struct packed {
        logic                     hit;
        logic [BCAM_MEMDBITS-1:0] addr;
    } lookup_res_t;

endpackage

// File: rtl/bcam_lookup_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index for the first
// requester at or after the rotating pointer. The pointer moves past the
// granted requester only when the owner signals advance.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    localparam int unsigned N = NUM_REQ;

    logic [ID_W-1:0] ptr_q;

    // Cyclic search starting at the pointer; first valid requester wins.
    always_comb begin
        int unsigned pos;
        logic        found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = 32'(ptr_q) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && req[ID_W'(pos)]) begin
                found                 = 1'b1;
                grant[ID_W'(pos)]     = 1'b1;
                grant_idx             = ID_W'(pos);
            end
        end
    end

    // Pointer advances to the requester after the granted one, wrapping at N-1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= '0;
        end else if (advance && |req) begin
            ptr_q <= (grant_idx == ID_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/bcam_lookup_arb.sv
// Shares one bcam match port between NUM_REQ requesters. Lookups are
// serialised: accept, issue one match_en cycle, wait LOOKUP_LAT, then
// return hit/index on a shared response channel tagged with the id.
// Optional statistics counters: define BCAM_LOOKUP_STATS_EN.
module bcam_lookup_arb
    import bcam_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int MEMLEN     = BCAM_MEMLEN,
    parameter int MEMDBITS   = BCAM_MEMDBITS,
    parameter int LOOKUP_LAT = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*MEMLEN-1:0] req_key,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_hit,
    output logic [MEMDBITS-1:0]       rsp_addr,
`ifdef BCAM_LOOKUP_STATS_EN
    input  logic                      stats_clr,
    output logic [31:0]               stat_lookups,
    output logic [31:0]               stat_hits,
`endif
    output logic                      cam_match_en,
    output logic [MEMLEN-1:0]         cam_data_in,
    input  logic                      cam_match,
    input  logic [MEMDBITS-1:0]       cam_match_addr
);

    localparam int CNT_W = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT + 1) : 1;

    lookup_state_t       state_q, state_nxt;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                advance;
    logic [MEMLEN-1:0]   sel_key;
    logic [MEMLEN-1:0]   key_q;
    logic [ID_W-1:0]     id_q;
    logic                hit_q;
    logic [MEMDBITS-1:0] addr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                rsp_fire;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req_valid),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Select the granted requester's key from the packed bus.
    always_comb begin
        sel_key = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_key = req_key[i*MEMLEN +: MEMLEN];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and handshake outputs; req_ready is also held low while
    // resetn is asserted so every output reads 0 during reset.
    always_comb begin
        state_nxt    = state_q;
        req_ready    = '0;
        advance      = 1'b0;
        cam_match_en = 1'b0;
        rsp_valid    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (resetn && |req_valid) begin
                    req_ready = grant;
                    advance   = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cam_match_en = 1'b1;
                state_nxt    = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign rsp_fire = rsp_valid && rsp_ready;

    // Lookup datapath: capture key/id at accept, time the bcam latency,
    // capture the result with the 1-based match address made 0-based.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_q  <= '0;
            id_q   <= '0;
            hit_q  <= 1'b0;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (advance) begin
                key_q <= sel_key;
                id_q  <= grant_idx;
            end
            if (state_q == ST_ISSUE) begin
                cnt_q <= CNT_W'(LOOKUP_LAT);
            end else if (state_q == ST_WAIT) begin
                if (cnt_q == CNT_W'(1)) begin
                    hit_q  <= cam_match;
                    addr_q <= cam_match ? cam_match_addr - MEMDBITS'(1) : '0;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign cam_data_in = key_q;
    assign rsp_id      = id_q;
    assign rsp_hit     = hit_q;
    assign rsp_addr    = addr_q;

`ifdef BCAM_LOOKUP_STATS_EN
    // Saturating lookup/hit counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
        end else if (stats_clr) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
        end else if (rsp_fire) begin
            if (stat_lookups != '1) begin
                stat_lookups <= stat_lookups + 1'b1;
            end
            if (hit_q && (stat_hits != '1)) begin
                stat_hits <= stat_hits + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/bcam_lookup_arb.md
Name: bcam_lookup_arb

Overview:
- Shares one bcam match port between NUM_REQ ingress requesters (router ingress parsers) using round-robin arbitration.
- Serialises lookups: accepts one key, drives the bcam match interface, and waits the fixed bcam latency.
- Captures the hit and the entry index, then returns them on a shared response channel tagged with the requester id.
- Sits between the ingress port logic and bcam; it is the only driver of bcam match_en and data_in.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, requester-id width, equal to clog2(NUM_REQ).
- MEMLEN, 32, key width; matches the bcam MEMLEN.
- MEMDBITS, 9, bcam address width.
- LOOKUP_LAT, 1, cycles from the match_en cycle to the cycle in which cam_match/cam_match_addr are valid (>=1).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester lookup request
- req_key  in  NUM_REQ*MEMLEN  packed keys; requester k uses bits [k*MEMLEN +: MEMLEN]
- req_ready  out  NUM_REQ  one-hot accept pulse
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  requester the response belongs to
- rsp_hit  out  1  key found
- rsp_addr  out  MEMDBITS  matching entry index (0-based)
- cam_match_en  out  1  to bcam match_en
- cam_data_in  out  MEMLEN  to bcam data_in
- cam_match  in  1  from bcam match
- cam_match_addr  in  MEMDBITS  from bcam match_addr (1-based count on a hit)

Behaviour:
- Reset (async, resetn=0): all outputs are 0, the FSM goes to IDLE, the RR pointer is 0 (requester 0 has highest priority), and the latched key/id/result are 0.
- FSM states:
  - IDLE: if any req_valid, pick the first requester at or after the RR pointer (cyclic). Drive req_ready[g]=1 for this cycle only, latch key and id, and go to ISSUE. The RR pointer becomes g+1 mod NUM_REQ.
  - ISSUE: cam_match_en=1 and cam_data_in=latched key for exactly 1 cycle; load the wait counter with LOOKUP_LAT; go to WAIT.
  - WAIT: decrement the counter. When it reaches 1, sample cam_match and cam_match_addr at that edge and go to RESP.
  - RESP: rsp_valid=1, with rsp_id/rsp_hit/rsp_addr held stable. On rsp_valid && rsp_ready, go to IDLE.
- cam_match_en is 0 in every state except ISSUE. cam_data_in holds the latched key at all times and is 0 after reset.
- Address fixup:
  - hit: rsp_addr = cam_match_addr - 1, modulo 2^MEMDBITS.
  - miss: rsp_hit=0 and rsp_addr=0.
- Latency, LOOKUP_LAT=1: accept at cycle T, match_en at T+1, sample at end of T+2, rsp_valid from T+3. Minimum 4 cycles per lookup; throughput is 1 lookup per 4 cycles with rsp_ready held high.
- req_ready is combinationally asserted only in IDLE for the granted index; it is never asserted for a requester with req_valid=0. A request dropped before its grant is simply not served.
- The id and key are captured in the accept cycle. Later changes on req_key do not affect the in-flight lookup.
- rsp_ready=0 in RESP stalls the block indefinitely; no new grants are issued and the outputs are held.
- Boundaries:
  - All requesters valid: strict rotation 0,1,2,3,0...
  - A single requester valid: served back-to-back.
  - Pointer wrap at NUM_REQ-1 goes to 0.
  - A hit at entry MEMDEPTH-1 reports rsp_addr=MEMDEPTH-1.
- Reset mid-operation: abort immediately. No response is produced for the aborted lookup, cam_match_en drops asynchronously, and the requester must re-request.

Optional Feature:
- Macro BCAM_LOOKUP_STATS_EN.
- Defined: adds input stats_clr (1) and outputs stat_lookups (32) and stat_hits (32).
  - stat_lookups increments on each RESP handshake; stat_hits increments when that handshake has rsp_hit=1.
  - Both saturate at 0xFFFFFFFF and reset to 0.
  - Synchronous stats_clr wins over a simultaneous increment.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package bcam_pkg: MEMLEN, MEMDBITS, MEMDEPTH defaults; FSM state encoding (IDLE, ISSUE, WAIT, RESP as a 2-bit typedef); the lookup-result struct (hit, addr).
- One sub-module: rr_arbiter (NUM_REQ-wide, inputs req/advance, outputs one-hot grant and encoded index). It is reusable for the future bcam write path.

Test Plan:
- Requester 1 valid with key 0x0000000C, bcam model holding 0x0C at entry 2 (match_addr=3) -> req_ready=0b0010 in 1 cycle; rsp_valid at T+3 with id=1, hit=1, addr=2.
- Requester 0 with key 0xDEADBEEF not present -> rsp hit=0, addr=0; cam_match_en high for exactly 1 cycle.
- All 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; each id appears once per 16 cycles.
- rsp_ready=0 for 10 cycles in RESP -> rsp fields stable, no req_ready pulses, cam_match_en=0; the response completes on release.
- resetn low during WAIT -> all outputs 0 immediately, no response; after release, requester 2's pending request is granted first only if requesters 0..1 are idle.
- With BCAM_LOOKUP_STATS_EN: 5 lookups with 3 hits -> stat_lookups=5, stat_hits=3; stats_clr pulse coinciding with a handshake -> both 0.
